// File: rtl/ps2_kbd_rx_fifo_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: prefixes, frame size, entry layout.
package ps2_kbd_rx_fifo_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned ENTRY_W        = 10;

    // FIFO entry: bit 9 = ext, bit 8 = brk, bits 7:0 = scan code
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
        return ^data_and_parity;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; no bypass, push accepted while full only with a pop.
module ps2_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; cleared on reset so the head reads as zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointer update
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frame checking, E0/F0 prefix folding and a buffered valid/ready output.
module ps2_kbd_rx_fifo
    import ps2_kbd_rx_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_brk,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    input  logic       err_clr
);

    localparam int unsigned      TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned      BITCNT_W  = 4;
    localparam logic [BITCNT_W-1:0] STOP_BIT  = BITCNT_W'(PS2_FRAME_BITS - 1);
    localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall_c;
    logic                   data_s;

    rx_state_t             state, state_nx;
    logic [BITCNT_W-1:0]   bitcnt, bitcnt_nx;
    logic [9:0]            shreg, shreg_nx;
    logic [TCNT_W-1:0]     tcnt, tcnt_nx;
    logic                  ext_pend, ext_nx;
    logic                  brk_pend, brk_nx;
    logic                  perr_nx, ferr_nx;
    logic                  push_c;
    logic                  pop_c;
    ps2_entry_t            entry_c;
    ps2_entry_t            head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Pin synchronisers, idle-high after reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_c = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Receive state machine register and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= RX_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            bitcnt     <= bitcnt_nx;
            shreg      <= shreg_nx;
            tcnt       <= tcnt_nx;
            ext_pend   <= ext_nx;
            brk_pend   <= brk_nx;
            parity_err <= perr_nx;
            frame_err  <= ferr_nx;
        end
    end

    // Next state: shift bits on each fall, check the frame at the stop bit, fold prefixes
    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        shreg_nx  = shreg;
        tcnt_nx   = tcnt;
        ext_nx    = ext_pend;
        brk_nx    = brk_pend;
        perr_nx   = 1'b0;
        ferr_nx   = 1'b0;
        push_c    = 1'b0;
        entry_c   = '{ext: ext_pend, brk: brk_pend, code: shreg[8:1]};

        case (state)
            RX_IDLE: begin
                if (fall_c) begin
                    shreg_nx  = {data_s, shreg[9:1]};
                    bitcnt_nx = BITCNT_W'(1);
                    tcnt_nx   = '0;
                    state_nx  = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (fall_c) begin
                    tcnt_nx = '0;
                    if (bitcnt == STOP_BIT) begin
                        // shreg: [0]=start, [8:1]=data, [9]=parity; data_s is the stop bit
                        state_nx  = RX_IDLE;
                        bitcnt_nx = '0;
                        if (shreg[0] || !data_s) begin
                            ferr_nx = 1'b1;
                            ext_nx  = 1'b0;
                            brk_nx  = 1'b0;
                        end else if (!odd_parity_ok(shreg[9:1])) begin
                            perr_nx = 1'b1;
                            ext_nx  = 1'b0;
                            brk_nx  = 1'b0;
                        end else if (shreg[8:1] == PS2_PREFIX_EXT) begin
                            ext_nx = 1'b1;
                        end else if (shreg[8:1] == PS2_PREFIX_BRK) begin
                            brk_nx = 1'b1;
                        end else begin
                            push_c = 1'b1;
                            ext_nx = 1'b0;
                            brk_nx = 1'b0;
                        end
                    end else begin
                        shreg_nx  = {data_s, shreg[9:1]};
                        bitcnt_nx = bitcnt + BITCNT_W'(1);
                    end
                end else if (tcnt == TCNT_LAST) begin
                    state_nx  = RX_IDLE;
                    bitcnt_nx = '0;
                    tcnt_nx   = '0;
                    ferr_nx   = 1'b1;
                    ext_nx    = 1'b0;
                    brk_nx    = 1'b0;
                end else begin
                    tcnt_nx = tcnt + TCNT_W'(1);
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    assign out_valid = ~fifo_empty;
    assign pop_c     = ~fifo_empty & out_ready;

    ps2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_c),
        .pop    (pop_c),
        .din    (entry_c),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_code = head.code;
    assign out_ext  = head.ext;
    assign out_brk  = head.brk;

    // Sticky overflow: a dropped push sets it, err_clr clears it, set wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (push_c && fifo_full && !pop_c) begin
            overflow <= 1'b1;
        end else if (err_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Self-checking bench for ps2_kbd_rx_fifo: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_ps2_kbd_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int TMO   = 300;
    localparam int HALF  = 50;   // 1 MHz clk, 10 kHz PS/2 clock

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_brk;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_kbd_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_ext    (out_ext),
        .out_brk    (out_brk),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr)
    );

    always #500 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int         cyc = 0;
    int         ev_due[$];
    bit         ev_bit[$];
    bit         fbits[$];
    bit         in_frame = 0;
    int         idle = 0;
    bit         ext_p = 0;
    bit         brk_p = 0;
    logic [9:0] mq[$];
    bit         m_ovf = 0;
    bit         m_perr = 0;
    bit         m_ferr = 0;
    int         n_perr = 0;
    int         n_ferr = 0;
    bit         rand_ready = 0;

    // Model: a PS/2 fall reaches the receiver SYNC+1 clock edges after the pin drops
    always @(posedge clk) begin : model
        bit         pop_m, fall_m, push_m, bit_m, par_m, drop_m;
        logic [7:0] b_m;
        cyc++;
        if (!resetn) begin
            ev_due.delete(); ev_bit.delete(); fbits.delete();
            in_frame = 0; idle = 0; ext_p = 0; brk_p = 0;
            mq.delete(); m_ovf = 0; m_perr = 0; m_ferr = 0;
        end else begin
            m_perr = 0; m_ferr = 0; push_m = 0; fall_m = 0; bit_m = 0; b_m = '0;
            pop_m = out_ready && (mq.size() > 0);
            if (ev_due.size() > 0 && ev_due[0] == cyc) begin
                fall_m = 1;
                bit_m  = ev_bit.pop_front();
                void'(ev_due.pop_front());
            end
            if (!in_frame) begin
                if (fall_m) begin
                    in_frame = 1; idle = 0;
                    fbits.delete(); fbits.push_back(bit_m);
                end
            end else if (fall_m) begin
                fbits.push_back(bit_m); idle = 0;
                if (fbits.size() == 11) begin
                    in_frame = 0;
                    par_m = 0;
                    for (int i = 1; i <= 9; i++) par_m ^= fbits[i];
                    for (int i = 0; i < 8; i++) b_m[i] = fbits[i+1];
                    if (fbits[0] != 0 || fbits[10] != 1) begin
                        m_ferr = 1; ext_p = 0; brk_p = 0;
                    end else if (!par_m) begin
                        m_perr = 1; ext_p = 0; brk_p = 0;
                    end else if (b_m == 8'hE0) begin
                        ext_p = 1;
                    end else if (b_m == 8'hF0) begin
                        brk_p = 1;
                    end else begin
                        push_m = 1;
                    end
                end
            end else begin
                idle++;
                if (idle == TMO) begin
                    in_frame = 0; m_ferr = 1; ext_p = 0; brk_p = 0;
                end
            end
            drop_m = push_m && (mq.size() == DEPTH) && !pop_m;
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                if (!drop_m) mq.push_back({ext_p, brk_p, b_m});
                ext_p = 0; brk_p = 0;
            end
            if (drop_m) m_ovf = 1;
            else if (err_clr) m_ovf = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : compare
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("out_code", out_code, mq[0][7:0]);
            chk("out_ext",  out_ext,  mq[0][9]);
            chk("out_brk",  out_brk,  mq[0][8]);
        end
        chk("parity_err", parity_err, m_perr);
        chk("frame_err",  frame_err,  m_ferr);
        chk("overflow",   overflow,   m_ovf);
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
    end

    // Random consumer during the random phase
    always @(negedge clk) begin
        if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
            err_clr   = ($urandom_range(0, 15) == 0);
        end
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par,
                                       input bit bad_start, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, bad_start};
    endfunction

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            gap(HALF);
            ps2_clk = 1'b0;
            ev_due.push_back(cyc + SYNC + 1);
            ev_bit.push_back(fr[i]);
            gap(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(mk(b, 0, 0, 0), 11);
        gap(10);
    endtask

    task automatic pop_one();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    task automatic expect_head(input string nm, input logic [7:0] c, input logic e, input logic b);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_code"},  out_code,  c);
        chk({nm, "_ext"},   out_ext,   e);
        chk({nm, "_brk"},   out_brk,   b);
        pop_one();
    endtask

    initial begin
        #150_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0, f0;
        bit bp, bs, bt;
        logic [7:0] rb;

        gap(4);
        chk("rst_valid", out_valid, 0);
        chk("rst_code",  out_code,  0);
        chk("rst_ext",   out_ext,   0);
        chk("rst_brk",   out_brk,   0);
        chk("rst_perr",  parity_err, 0);
        chk("rst_ferr",  frame_err, 0);
        chk("rst_ovf",   overflow,  0);
        resetn = 1'b1;
        gap(5);

        p0 = n_perr; f0 = n_ferr;
        send(8'h1C);
        expect_head("make1c", 8'h1C, 0, 0);
        chk("make1c_empty", out_valid, 0);
        chk("make1c_noerr", n_perr + n_ferr, p0 + f0);

        send(8'hF0); send(8'h1C);
        expect_head("brk1c", 8'h1C, 0, 1);
        chk("brk1c_empty", out_valid, 0);

        send(8'hE0); send(8'hF0); send(8'h75);
        expect_head("extbrk75", 8'h75, 1, 1);
        chk("extbrk75_empty", out_valid, 0);

        p0 = n_perr;
        send_frame(mk(8'h1C, 1, 0, 0), 11); gap(10);
        chk("badpar_pulse", n_perr - p0, 1);
        chk("badpar_noentry", out_valid, 0);
        send(8'hF0); send(8'h1C);
        expect_head("after_badpar", 8'h1C, 0, 1);

        f0 = n_ferr;
        send_frame(mk(8'h1C, 0, 0, 1), 11); gap(10);
        chk("badstop_pulse", n_ferr - f0, 1);
        chk("badstop_noentry", out_valid, 0);

        f0 = n_ferr;
        send_frame(mk(8'h5A, 0, 0, 0), 5); gap(TMO + 20);
        chk("timeout_pulse", n_ferr - f0, 1);
        send(8'h2A);
        expect_head("after_tmo", 8'h2A, 0, 0);

        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        chk("ovf_set", overflow, 1);
        for (int i = 0; i < 8; i++) expect_head("drain", 8'h10 + 8'(i), 0, 0);
        chk("drain_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        send(8'h21);
        send_frame(mk(8'h33, 0, 0, 0), 4); gap(20);
        p0 = n_perr; f0 = n_ferr;
        resetn = 1'b0;
        gap(3);
        resetn = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_code",  out_code,  0);
        chk("midrst_ext",   out_ext,   0);
        chk("midrst_brk",   out_brk,   0);
        chk("midrst_ovf",   overflow,  0);
        gap(TMO + 20);
        chk("midrst_nopulse", n_perr + n_ferr, p0 + f0);
        send(8'h33);
        expect_head("after_rst", 8'h33, 0, 0);

        rand_ready = 1;
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hE0;
                2, 3:    rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            bt = ($urandom_range(0, 14) == 0);
            if (k == 12) begin
                send_frame(mk(rb, 0, 0, 0), 3);
                gap(TMO + 10);
            end else begin
                send_frame(mk(rb, bp, bs, bt), 11);
                gap(int'($urandom_range(5, 40)));
            end
        end
        rand_ready = 0;
        err_clr = 1'b0;
        out_ready = 1'b1;
        gap(DEPTH + 10);
        out_ready = 1'b0;
        gap(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
